// File: rtl/pipe_controller.sv
// pipe_controller
// ---------------------------------------------------------------------------
// Registered main decoder at the ID/EX boundary of the RISC-V pipeline.
// Decodes opcode (plus funct7 for M-extension ops) into the control bundle
// one cycle after the instruction is sampled. It also sequences multi-cycle
// mul/div issue, a sticky HALT state, flush bubbles and illegal-opcode pulses.
//
// Parameters
//   MULDIV_EN   : 1 = R-type with funct7 0000001 issues a mul/div, 0 = illegal
//   MD_LATENCY  : mul/div busy cycles (1..32)
//   HALT_OPCODE : opcode that halts the core
//
// Ports
//   clk, reset            : core clock, asynchronous active-low reset
//   valid_i               : ID instruction is valid
//   opcode, funct7        : instruction[6:0], instruction[31:25]
//   flush                 : squash the ID instruction
//   stall_ext             : downstream not ready; freeze every register
//   ALUSrc .. jalrsel     : registered control bits
//   ALUOp, RWSel          : registered ALU op class / write-data select
//   md_start              : one-cycle pulse, mul/div issued
//   ctrl_valid_o          : bundle holds a real instruction (0 = bubble)
//   stall_o               : hold IF/ID (from state)
//   halted_o              : core halted, sticky until reset
//   illegal_o             : one-cycle pulse, illegal opcode decoded
// ---------------------------------------------------------------------------
module pipe_controller #(
    parameter bit         MULDIV_EN   = 1'b1,
    parameter int         MD_LATENCY  = 4,
    parameter logic [6:0] HALT_OPCODE = 7'b0000001
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       valid_i,
    input  logic [6:0] opcode,
    input  logic [6:0] funct7,
    input  logic       flush,
    input  logic       stall_ext,
    output logic       ALUSrc,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       Branch,
    output logic       jalrsel,
    output logic [1:0] ALUOp,
    output logic [1:0] RWSel,
    output logic       md_start,
    output logic       ctrl_valid_o,
    output logic       stall_o,
    output logic       halted_o,
    output logic       illegal_o
);

    localparam int               CNT_W    = $clog2(MD_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_LATENCY - 1);

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] F7_MD   = 7'b0000001;

    typedef enum logic [1:0] {RUN, MULDIV, HALTED} state_t;

    typedef struct packed {
        logic       alu_src, mem_to_reg, reg_write, mem_read, mem_write;
        logic       branch, jalr_sel;
        logic [1:0] alu_op;
        logic [1:0] rw_sel;
        logic       md_start;
        logic       ctrl_valid;
        logic       illegal;
    } ctrl_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    ctrl_t            ctrl, ctrl_next;
    ctrl_t            dec;
    logic             legal, is_halt, is_md;

    // Pure opcode decode, independent of state and handshakes.
    // NOTE: every signal written in a combinational block gets a default
    // first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        dec     = '0;
        legal   = 1'b1;
        is_halt = 1'b0;
        is_md   = 1'b0;
        if (opcode == HALT_OPCODE) begin
            is_halt    = 1'b1;
            dec.branch = 1'b1;
            dec.alu_op = 2'b11;
        end else begin
            case (opcode)
                OP_R: begin
                    dec.reg_write = 1'b1;
                    dec.alu_op    = 2'b10;
                    if (funct7 == F7_MD) begin
                        if (MULDIV_EN) begin
                            is_md        = 1'b1;
                            dec.md_start = 1'b1;
                        end else begin
                            legal = 1'b0;
                        end
                    end
                end
                OP_I: begin
                    dec.alu_src   = 1'b1;
                    dec.reg_write = 1'b1;
                    dec.alu_op    = 2'b10;
                end
                OP_LUI: begin
                    dec.reg_write = 1'b1;
                    dec.alu_op    = 2'b11;
                    dec.rw_sel    = 2'b11;
                end
                OP_LW: begin
                    dec.alu_src    = 1'b1;
                    dec.mem_to_reg = 1'b1;
                    dec.reg_write  = 1'b1;
                    dec.mem_read   = 1'b1;
                end
                OP_SW: begin
                    dec.alu_src   = 1'b1;
                    dec.mem_write = 1'b1;
                end
                OP_BR: begin
                    dec.branch = 1'b1;
                    dec.alu_op = 2'b01;
                end
                OP_JAL: begin
                    dec.reg_write = 1'b1;
                    dec.branch    = 1'b1;
                    dec.alu_op    = 2'b11;
                    dec.rw_sel    = 2'b01;
                end
                OP_JALR: begin
                    dec.alu_src   = 1'b1;
                    dec.reg_write = 1'b1;
                    dec.branch    = 1'b1;
                    dec.jalr_sel  = 1'b1;
                    dec.alu_op    = 2'b10;
                    dec.rw_sel    = 2'b01;
                end
                default: legal = 1'b0;
            endcase
        end
    end

    // Next state and next registered bundle; the default bundle is a bubble.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        ctrl_next  = '0;
        case (state)
            RUN: begin
                if (flush || !valid_i) begin
                    ctrl_next = '0;
                end else if (!legal) begin
                    ctrl_next.illegal = 1'b1;
                end else begin
                    ctrl_next            = dec;
                    ctrl_next.ctrl_valid = 1'b1;
                    if (is_halt) begin
                        state_next = HALTED;
                    end else if (is_md) begin
                        cnt_next   = CNT_LOAD;
                        state_next = MULDIV;
                    end
                end
            end
            // An issued mul/div runs to completion; flush cannot abort it.
            MULDIV: begin
                if (cnt == '0) begin
                    state_next = RUN;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            HALTED:  state_next = HALTED;
            default: state_next = RUN;
        endcase
    end

    // stall_ext freezes everything, so pulses are held rather than re-issued.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RUN;
            cnt   <= '0;
            ctrl  <= '0;
        end else if (!stall_ext) begin
            state <= state_next;
            cnt   <= cnt_next;
            ctrl  <= ctrl_next;
        end
    end

    assign ALUSrc       = ctrl.alu_src;
    assign MemtoReg     = ctrl.mem_to_reg;
    assign RegWrite     = ctrl.reg_write;
    assign MemRead      = ctrl.mem_read;
    assign MemWrite     = ctrl.mem_write;
    assign Branch       = ctrl.branch;
    assign jalrsel      = ctrl.jalr_sel;
    assign ALUOp        = ctrl.alu_op;
    assign RWSel        = ctrl.rw_sel;
    assign md_start     = ctrl.md_start;
    assign ctrl_valid_o = ctrl.ctrl_valid;
    assign illegal_o    = ctrl.illegal;
    assign stall_o      = (state == MULDIV) || (state == HALTED);
    assign halted_o     = (state == HALTED);

endmodule

// File: tb/tb_pipe_controller.sv
// tb_pipe_controller
// Directed bench for pipe_controller. Three instances share the inputs:
//   u_dut  : MULDIV_EN=1, MD_LATENCY=4
//   u_nomd : MULDIV_EN=0, MD_LATENCY=4
//   u_lat1 : MULDIV_EN=1, MD_LATENCY=1
// Each output bundle is gathered as
//   {ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,jalrsel,ALUOp,RWSel,
//    md_start,ctrl_valid_o,illegal_o}
module tb_pipe_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       valid_i;
    logic [6:0] opcode;
    logic [6:0] funct7;
    logic       flush;
    logic       stall_ext;

    wire [13:0] bun0, bun1, bun2;
    wire        stall0, stall1, stall2;
    wire        halted0, halted1, halted2;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_HALT = 7'b0000001;
    localparam logic [6:0] OP_BAD  = 7'b1111111;

    logic [13:0] E_LW, E_SW, E_BR, E_JAL, E_JALR, E_LUI, E_R, E_I;
    logic [13:0] E_HALT, E_MUL, E_ILL;

    always #5 clk = ~clk;

    pipe_controller #(.MULDIV_EN(1'b1), .MD_LATENCY(4)) u_dut (
        .clk(clk), .reset(reset), .valid_i(valid_i), .opcode(opcode),
        .funct7(funct7), .flush(flush), .stall_ext(stall_ext),
        .ALUSrc(bun0[13]), .MemtoReg(bun0[12]), .RegWrite(bun0[11]),
        .MemRead(bun0[10]), .MemWrite(bun0[9]), .Branch(bun0[8]),
        .jalrsel(bun0[7]), .ALUOp(bun0[6:5]), .RWSel(bun0[4:3]),
        .md_start(bun0[2]), .ctrl_valid_o(bun0[1]), .stall_o(stall0),
        .halted_o(halted0), .illegal_o(bun0[0])
    );

    pipe_controller #(.MULDIV_EN(1'b0), .MD_LATENCY(4)) u_nomd (
        .clk(clk), .reset(reset), .valid_i(valid_i), .opcode(opcode),
        .funct7(funct7), .flush(flush), .stall_ext(stall_ext),
        .ALUSrc(bun1[13]), .MemtoReg(bun1[12]), .RegWrite(bun1[11]),
        .MemRead(bun1[10]), .MemWrite(bun1[9]), .Branch(bun1[8]),
        .jalrsel(bun1[7]), .ALUOp(bun1[6:5]), .RWSel(bun1[4:3]),
        .md_start(bun1[2]), .ctrl_valid_o(bun1[1]), .stall_o(stall1),
        .halted_o(halted1), .illegal_o(bun1[0])
    );

    pipe_controller #(.MULDIV_EN(1'b1), .MD_LATENCY(1)) u_lat1 (
        .clk(clk), .reset(reset), .valid_i(valid_i), .opcode(opcode),
        .funct7(funct7), .flush(flush), .stall_ext(stall_ext),
        .ALUSrc(bun2[13]), .MemtoReg(bun2[12]), .RegWrite(bun2[11]),
        .MemRead(bun2[10]), .MemWrite(bun2[9]), .Branch(bun2[8]),
        .jalrsel(bun2[7]), .ALUOp(bun2[6:5]), .RWSel(bun2[4:3]),
        .md_start(bun2[2]), .ctrl_valid_o(bun2[1]), .stall_o(stall2),
        .halted_o(halted2), .illegal_o(bun2[0])
    );

    // bits = {ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,jalrsel}
    function automatic logic [13:0] bundle(input logic [6:0] bits,
                                           input logic [1:0] alu_op,
                                           input logic [1:0] rw_sel,
                                           input logic md, input logic v,
                                           input logic il);
        return {bits, alu_op, rw_sel, md, v, il};
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [6:0] op, input logic [6:0] f7);
        valid_i = v;
        opcode  = op;
        funct7  = f7;
    endtask

    task automatic do_reset;
        reset     = 1'b0;
        valid_i   = 1'b0;
        opcode    = '0;
        funct7    = '0;
        flush     = 1'b0;
        stall_ext = 1'b0;
        step();
        reset = 1'b1;
    endtask

    task automatic test_reset;
        reset = 1'b0; valid_i = 1'b1; opcode = OP_LW; funct7 = '0;
        flush = 1'b0; stall_ext = 1'b0;
        step(); step();
        n_checks++;
        if ({bun0, bun1, bun2} !== '0) begin
            n_fail++;
            $display("FAIL reset bundles: got %h %h %h expected 0", bun0, bun1, bun2);
        end
        n_checks++;
        if ({stall0, stall1, stall2, halted0, halted1, halted2} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset status: got stall %b%b%b halted %b%b%b expected all 0",
                     stall0, stall1, stall2, halted0, halted1, halted2);
        end
        reset = 1'b1;
        #2;
        n_checks++;
        if (bun0 !== 14'b0) begin
            n_fail++;
            $display("FAIL reset release: got %b expected 0 before first edge", bun0);
        end
    endtask

    task automatic test_decode;
        logic [6:0]  ops [8];
        logic [13:0] exps[8];
        string       names[8];
        ops   = '{OP_LW, OP_SW, OP_BR, OP_JAL, OP_JALR, OP_LUI, OP_R, OP_I};
        exps  = '{E_LW, E_SW, E_BR, E_JAL, E_JALR, E_LUI, E_R, E_I};
        names = '{"lw", "sw", "br", "jal", "jalr", "lui", "r", "i"};
        do_reset();
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, ops[k], 7'b0);
            step();
            n_checks++;
            if (bun0 !== exps[k]) begin
                n_fail++;
                $display("FAIL decode %s: got %b expected %b", names[k], bun0, exps[k]);
            end
        end
        // funct7=0000001 only means mul/div on R-type; SUB stays legal everywhere.
        drive(1'b1, OP_I, 7'b0000001);
        step();
        n_checks++;
        if (bun0 !== E_I) begin
            n_fail++;
            $display("FAIL decode i funct7=1: got %b expected %b", bun0, E_I);
        end
        drive(1'b1, OP_R, 7'b0100000);
        step();
        n_checks++;
        if (bun1 !== E_R) begin
            n_fail++;
            $display("FAIL decode sub nomd: got %b expected %b", bun1, E_R);
        end
        drive(1'b0, OP_R, 7'b0);
        step();
    endtask

    task automatic test_muldiv;
        do_reset();
        drive(1'b1, OP_R, 7'b0000001);
        step();                                 // edge N
        n_checks++;
        if (bun0 !== E_MUL || stall0 !== 1'b1) begin
            n_fail++;
            $display("FAIL mul issue: got %b stall %b expected %b stall 1", bun0, stall0, E_MUL);
        end
        n_checks++;
        if (bun1 !== E_ILL) begin
            n_fail++;
            $display("FAIL mul nomd illegal: got %b expected %b", bun1, E_ILL);
        end
        n_checks++;
        if (bun2 !== E_MUL || stall2 !== 1'b1) begin
            n_fail++;
            $display("FAIL mul lat1 issue: got %b stall %b expected %b stall 1", bun2, stall2, E_MUL);
        end
        drive(1'b1, OP_R, 7'b0);
        flush = 1'b1;
        step();                                 // N+1
        n_checks++;
        if (bun0 !== 14'b0 || stall0 !== 1'b1) begin
            n_fail++;
            $display("FAIL mul N+1: got %b stall %b expected 0 stall 1", bun0, stall0);
        end
        n_checks++;
        if (bun2 !== 14'b0 || stall2 !== 1'b0) begin
            n_fail++;
            $display("FAIL mul lat1 N+1: got %b stall %b expected 0 stall 0", bun2, stall2);
        end
        step();                                 // N+2, flush cannot abort
        n_checks++;
        if (bun0 !== 14'b0 || stall0 !== 1'b1) begin
            n_fail++;
            $display("FAIL mul N+2: got %b stall %b expected 0 stall 1", bun0, stall0);
        end
        flush = 1'b0;
        step();                                 // N+3
        n_checks++;
        if (bun0 !== 14'b0 || stall0 !== 1'b1) begin
            n_fail++;
            $display("FAIL mul N+3: got %b stall %b expected 0 stall 1", bun0, stall0);
        end
        n_checks++;
        if (bun1 !== E_R || bun2 !== E_R) begin
            n_fail++;
            $display("FAIL mul others N+3: got %b %b expected %b", bun1, bun2, E_R);
        end
        step();                                 // N+4: RUN resumes
        n_checks++;
        if (stall0 !== 1'b0) begin
            n_fail++;
            $display("FAIL mul N+4 stall: got %b expected 0", stall0);
        end
        step();                                 // N+5
        n_checks++;
        if (bun0 !== E_R || stall0 !== 1'b0) begin
            n_fail++;
            $display("FAIL mul N+5 add: got %b stall %b expected %b stall 0", bun0, stall0, E_R);
        end
    endtask

    task automatic test_halt;
        int bad;
        do_reset();
        drive(1'b1, OP_HALT, 7'b0);
        step();
        n_checks++;
        if (bun0 !== E_HALT || halted0 !== 1'b1 || stall0 !== 1'b1) begin
            n_fail++;
            $display("FAIL halt entry: got %b halted %b stall %b expected %b 1 1",
                     bun0, halted0, stall0, E_HALT);
        end
        drive(1'b1, OP_LW, 7'b0);
        bad = 0;
        for (int k = 0; k < 22; k++) begin
            flush = (k == 5);
            step();
            if (bun0 !== 14'b0 || halted0 !== 1'b1 || stall0 !== 1'b1) bad++;
        end
        flush = 1'b0;
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL halt sticky: got %0d bad cycles of 22 expected 0", bad);
        end
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if (bun0 !== 14'b0 || halted0 !== 1'b0 || stall0 !== 1'b0) begin
            n_fail++;
            $display("FAIL halt async reset: got %b halted %b stall %b expected 0 0 0",
                     bun0, halted0, stall0);
        end
        reset = 1'b1;
        step();
        n_checks++;
        if (bun0 !== E_LW || halted0 !== 1'b0) begin
            n_fail++;
            $display("FAIL halt resume: got %b halted %b expected %b 0", bun0, halted0, E_LW);
        end
    endtask

    task automatic test_illegal;
        do_reset();
        drive(1'b1, OP_BAD, 7'b0);
        step();
        n_checks++;
        if (bun0 !== E_ILL) begin
            n_fail++;
            $display("FAIL illegal pulse: got %b expected %b", bun0, E_ILL);
        end
        drive(1'b0, OP_BAD, 7'b0);
        step();
        n_checks++;
        if (bun0 !== 14'b0) begin
            n_fail++;
            $display("FAIL illegal one cycle: got %b expected 0", bun0);
        end
        drive(1'b0, OP_LW, 7'b0);
        step();
        n_checks++;
        if (bun0 !== 14'b0) begin
            n_fail++;
            $display("FAIL invalid lw bubble: got %b expected 0", bun0);
        end
    endtask

    task automatic test_flush;
        do_reset();
        drive(1'b1, OP_LW, 7'b0);
        flush = 1'b1;
        step();
        n_checks++;
        if (bun0 !== 14'b0) begin
            n_fail++;
            $display("FAIL flush lw: got %b expected 0", bun0);
        end
        drive(1'b1, OP_HALT, 7'b0);
        step();
        n_checks++;
        if (bun0 !== 14'b0 || halted0 !== 1'b0 || stall0 !== 1'b0) begin
            n_fail++;
            $display("FAIL flush halt: got %b halted %b stall %b expected 0 0 0",
                     bun0, halted0, stall0);
        end
        flush = 1'b0;
        drive(1'b1, OP_LW, 7'b0);
        step();
        n_checks++;
        if (bun0 !== E_LW || halted0 !== 1'b0) begin
            n_fail++;
            $display("FAIL flush release: got %b halted %b expected %b 0", bun0, halted0, E_LW);
        end
    endtask

    task automatic test_stall_ext;
        int bad;
        do_reset();
        drive(1'b1, OP_R, 7'b0000001);
        step();                                 // issue at N
        n_checks++;
        if (bun0 !== E_MUL) begin
            n_fail++;
            $display("FAIL stall_ext issue: got %b expected %b", bun0, E_MUL);
        end
        drive(1'b1, OP_R, 7'b0);
        stall_ext = 1'b1;
        bad = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            if (bun0 !== E_MUL || stall0 !== 1'b1) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL stall_ext freeze: got %0d bad cycles of 3 expected 0", bad);
        end
        stall_ext = 1'b0;
        bad = 0;
        for (int k = 0; k < 3; k++) begin   // N+4..N+6: countdown resumes
            step();
            if (bun0 !== 14'b0 || stall0 !== 1'b1) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL stall_ext countdown: got %0d bad cycles of 3 expected 0", bad);
        end
        step();                                 // N+7
        n_checks++;
        if (stall0 !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_ext total length: stall got %b expected 0 at N+7", stall0);
        end
        drive(1'b1, OP_LW, 7'b0);
        step();
        drive(1'b1, OP_SW, 7'b0);
        stall_ext = 1'b1;
        flush     = 1'b1;
        step();
        n_checks++;
        if (bun0 !== E_LW) begin
            n_fail++;
            $display("FAIL stall_ext over flush: got %b expected %b", bun0, E_LW);
        end
        stall_ext = 1'b0;
        step();
        n_checks++;
        if (bun0 !== 14'b0) begin
            n_fail++;
            $display("FAIL flush after stall_ext: got %b expected 0", bun0);
        end
        flush = 1'b0;
        drive(1'b1, OP_BAD, 7'b0);
        step();
        stall_ext = 1'b1;
        step();
        n_checks++;
        if (bun0 !== E_ILL) begin
            n_fail++;
            $display("FAIL illegal held by stall_ext: got %b expected %b", bun0, E_ILL);
        end
        stall_ext = 1'b0;
        drive(1'b0, OP_BAD, 7'b0);
        step();
    endtask

    initial begin
        E_LW   = bundle(7'b1111000, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
        E_SW   = bundle(7'b1000100, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
        E_BR   = bundle(7'b0000010, 2'b01, 2'b00, 1'b0, 1'b1, 1'b0);
        E_JAL  = bundle(7'b0010010, 2'b11, 2'b01, 1'b0, 1'b1, 1'b0);
        E_JALR = bundle(7'b1010011, 2'b10, 2'b01, 1'b0, 1'b1, 1'b0);
        E_LUI  = bundle(7'b0010000, 2'b11, 2'b11, 1'b0, 1'b1, 1'b0);
        E_R    = bundle(7'b0010000, 2'b10, 2'b00, 1'b0, 1'b1, 1'b0);
        E_I    = bundle(7'b1010000, 2'b10, 2'b00, 1'b0, 1'b1, 1'b0);
        E_HALT = bundle(7'b0000010, 2'b11, 2'b00, 1'b0, 1'b1, 1'b0);
        E_MUL  = bundle(7'b0010000, 2'b10, 2'b00, 1'b1, 1'b1, 1'b0);
        E_ILL  = bundle(7'b0000000, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1);

        test_reset();
        test_decode();
        test_muldiv();
        test_halt();
        test_illegal();
        test_flush();
        test_stall_ext();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
